vector_a_loader: RTL and testbench
==================================

VECTOR_A_LOADER -- requirements
Module: vector_a_loader

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 8: words per load burst, legal range 1..8.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255: idle-input limit in LOAD, legal range 1..255, used only when the timeout feature is compiled in.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a new burst; sampled only in IDLE.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: loader can accept a word.
REQ-008 The block SHALL have port in_data, input, 34 bits: upstream word.
REQ-009 The block SHALL have port w_en, output, 1 bit: write strobe to the vector-A register file.
REQ-010 The block SHALL have port w_addr, output, 3 bits: register-file write address.
REQ-011 The block SHALL have port w_data, output, 34 bits: register-file write data.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst is complete and committed.
REQ-014 The block SHALL have port error, output, 1 bit: one-cycle pulse when a burst is aborted by timeout.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD, DRAIN and DONE.
REQ-016 In IDLE, the block SHALL move to LOAD on the next edge when start=1, and SHALL clear the word index idx to 0.
REQ-017 In any state other than IDLE, the block SHALL ignore start.
REQ-018 The block SHALL drive in_ready=1 only in LOAD; a word is accepted in any cycle where in_valid and in_ready are both 1.
REQ-019 For a word accepted in cycle N, the block SHALL drive w_en=1, w_addr=idx and w_data=in_data in cycle N+1; all three outputs are registered.
REQ-020 When no word is accepted in a cycle, the block SHALL drive w_en=0 in the next cycle and SHALL hold w_addr and w_data at their last values.
REQ-021 On each accepted word, the block SHALL increment idx by 1.
REQ-022 On acceptance of the word with idx=NUM_WORDS-1, the block SHALL move to DRAIN; idx never wraps past NUM_WORDS-1 within a burst.
REQ-023 DRAIN SHALL last exactly one cycle, during which the final w_en is high and in_ready=0; the block SHALL then move to DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, after which the block SHALL return to IDLE; the last word is therefore committed one edge before done rises.
REQ-025 Stalls (in_valid=0 in LOAD) SHALL insert no writes and SHALL NOT change idx.
REQ-026 When start=1 is held into the DONE cycle, the block SHALL NOT begin a new burst until it has returned to IDLE.

Reset
REQ-027 Asserting rst SHALL immediately force: state=IDLE, idx=0, in_ready=0, w_en=0, w_addr=0, w_data=0, busy=0, done=0, error=0.
REQ-028 Asserting rst in the middle of a burst SHALL abort the burst with no further writes and no done pulse.

Configuration
REQ-029 When the macro VECTOR_A_LOADER_TIMEOUT_EN is defined, an 8-bit counter SHALL count consecutive LOAD cycles with in_valid=0 and SHALL clear on each accepted word and on entry to LOAD.
REQ-030 With VECTOR_A_LOADER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL pulse error for one cycle, return to IDLE with no DONE state, and leave already-written words in the register file.
REQ-031 When VECTOR_A_LOADER_TIMEOUT_EN is undefined, error SHALL be tied to 0 and LOAD SHALL wait indefinitely.

Verification
REQ-032 Reset, start, then 8 back-to-back words 0x1..0x8: w_en is high for 8 consecutive cycles with w_addr 0..7; done rises 2 cycles after the last accept; the register file holds 0x1..0x8.
REQ-033 Same burst with in_valid=0 for 3 cycles after word 4: w_en has a 3-cycle gap, w_addr resumes at 4, and done is delayed by 3 cycles.
REQ-034 With NUM_WORDS=3, load 0x2AAAAAAAA, 0x155555555, 0x3FFFFFFFF: exactly 3 writes to addresses 0..2, then done; in_ready is low in DRAIN.
REQ-035 Assert rst after 5 accepted words: all outputs clear the same cycle, no done; a new start writes again from address 0.
REQ-036 With VECTOR_A_LOADER_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, start then 2 words then in_valid=0: error pulses once after 4 idle cycles, busy falls, done never rises.
REQ-037 Hold start=1 continuously: bursts run back-to-back, each separated by one IDLE cycle after DONE.

Source files
------------

// File: rtl/vector_a_loader.sv
// vector_a_loader: burst loader for the vector-A register file.
//
// Accepts NUM_WORDS words from a valid/ready upstream and writes them to
// consecutive register-file addresses 0..NUM_WORDS-1. Writes are registered,
// so a word accepted in cycle N is written in cycle N+1. After the last word,
// DRAIN covers that final write and DONE pulses `done` for one cycle.
//
// Optional feature: define VECTOR_A_LOADER_TIMEOUT_EN to abort a burst that
// sees TIMEOUT_CYCLES consecutive LOAD cycles without in_valid. An abort
// pulses `error` and returns to IDLE. Without the macro, `error` is tied to 0
// and LOAD waits indefinitely.
//
// Parameters:
//   NUM_WORDS      words per burst (1..8)
//   TIMEOUT_CYCLES idle-input limit in LOAD (1..255), timeout build only
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     request a burst (sampled only in IDLE)
//   in_valid  upstream word valid
//   in_ready  loader accepts a word (LOAD only)
//   in_data   upstream word, 34 bits
//   w_en      register-file write strobe (registered)
//   w_addr    register-file write address (registered, holds when idle)
//   w_data    register-file write data (registered, holds when idle)
//   busy      state is not IDLE
//   done      one-cycle pulse in DONE
//   error     one-cycle pulse after a timeout abort
module vector_a_loader #(
  parameter int unsigned NUM_WORDS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [33:0] in_data,
  output logic        w_en,
  output logic [2:0]  w_addr,
  output logic [33:0] w_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  if (NUM_WORDS < 1 || NUM_WORDS > 8) begin : g_bad_num_words
    $error("vector_a_loader: NUM_WORDS must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("vector_a_loader: TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [2:0] LastIdx = 3'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        accept;
  logic        timeout;

  logic        w_en_q;
  logic [2:0]  w_addr_q;
  logic [33:0] w_data_q;

  assign in_ready = (state_q == StLoad);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign w_en     = w_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;

`ifdef VECTOR_A_LOADER_TIMEOUT_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       error_q;

  // The counter is held at zero in IDLE, which covers the clear on entry
  // to LOAD. In LOAD, a cycle without an accept is a cycle without in_valid.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (state_q != StLoad) begin
      idle_cnt_d = '0;
    end else if (accept) begin
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 8'd1;
      timeout    = (idle_cnt_d == TimeoutLimit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      error_q    <= timeout;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          // idx stays on the last address; it is cleared when the next burst starts
          if (idx_q == LastIdx) begin
            state_d = StDrain;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Registered write port; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_en_q <= accept;
      if (accept) begin
        w_addr_q <= idx_q;
        w_data_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_vector_a_loader.sv
// Bench for vector_a_loader: cycle table, write scoreboard, hand sequences.
module tb_vector_a_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_ready;
  logic [33:0] in_data;
  logic        w_en;
  logic [2:0]  w_addr;
  logic [33:0] w_data;
  logic        busy, done, error;

  logic        start3, in_valid3, in_ready3;
  logic [33:0] in_data3;
  logic        w_en3;
  logic [2:0]  w_addr3;
  logic [33:0] w_data3;
  logic        busy3, done3, error3;

  always #5 clk = ~clk;

  vector_a_loader #(.NUM_WORDS(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .error(error)
  );

  vector_a_loader #(.NUM_WORDS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .w_en(w_en3), .w_addr(w_addr3), .w_data(w_data3),
    .busy(busy3), .done(done3), .error(error3)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected register-file writes for the 8-word instance.
  typedef struct {
    logic [2:0]  addr;
    logic [33:0] data;
  } wr_t;
  wr_t         sb[$];
  logic [33:0] rf [8];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          wr_cnt   = 0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (w_en) begin
      wr_t e;
      wr_cnt = wr_cnt + 1;
      rf[w_addr] = w_data;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(w_addr), 64'hFFFF);
      end else begin
        e = sb.pop_front();
        check("sb_addr", 64'(w_addr), 64'(e.addr));
        check("sb_data", 64'(w_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned a, input logic [33:0] d);
    wr_t e;
    e.addr = 3'(a);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    start3 = 1'b0; in_valid3 = 1'b0; in_data3 = '0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // Start plus 8 back-to-back words base+1..base+8; returns last accept cycle.
  task automatic run_burst(input logic [33:0] base, output int last_acc);
    start = 1'b1;
    tick();
    start = 1'b0;
    last_acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = base + 34'(i + 1);
      push(i, in_data);
      last_acc = cyc;
      tick();
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic        v;
    logic [33:0] d;
    logic        rdy;
    logic        wen;
    logic [2:0]  wa;
    logic [33:0] wd;
    logic        bsy;
    logic        dn;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic v, input logic [33:0] d,
                              input logic rdy, input logic wen, input logic [2:0] wa,
                              input logic [33:0] wd, input logic bsy, input logic dn);
    vec_t r;
    r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.wen = wen;
    r.wa = wa; r.wd = wd; r.bsy = bsy; r.dn = dn;
    return r;
  endfunction

  vec_t tbl [15];

  initial begin
    int last_acc;
    int dc0;
    int wc0;
    int exp_idx;

    // Burst with a 3-cycle stall after word 4: per-cycle inputs and outputs.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 2, 1, 1, 0, 1, 1, 0);
    tbl[3]  = mk(0, 1, 3, 1, 1, 1, 2, 1, 0);
    tbl[4]  = mk(0, 1, 4, 1, 1, 2, 3, 1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 1, 3, 4, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 3, 4, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 3, 4, 1, 0);
    tbl[8]  = mk(0, 1, 5, 1, 0, 3, 4, 1, 0);
    tbl[9]  = mk(0, 1, 6, 1, 1, 4, 5, 1, 0);
    tbl[10] = mk(0, 1, 7, 1, 1, 5, 6, 1, 0);
    tbl[11] = mk(0, 1, 8, 1, 1, 6, 7, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 7, 8, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 7, 8, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 7, 8, 0, 0);

    for (int i = 0; i < 8; i++) rf[i] = '0;
    @(negedge clk);
    do_reset();

    // Reset state, observed while reset is held.
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_w_en", 64'(w_en), 0);
    check("rst_w_addr", 64'(w_addr), 0);
    check("rst_w_data", 64'(w_data), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    tick();
    rst = 1'b0;

    // Back-to-back 8-word burst 0x1..0x8.
    dc0 = done_cnt;
    wc0 = wr_cnt;
    run_burst(34'h0, last_acc);
    repeat (4) tick();
    check("b2b_done_count", 64'(done_cnt - dc0), 1);
    check("b2b_done_latency", 64'(done_cyc - last_acc), 2);
    check("b2b_write_count", 64'(wr_cnt - wc0), 8);
    for (int i = 0; i < 8; i++) check("b2b_rf", 64'(rf[i]), 64'(i + 1));

    // Stalled burst from the table.
    do_reset();
    exp_idx = 0;
    for (int i = 0; i < 15; i++) begin
      start    = tbl[i].st;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      if (tbl[i].v && tbl[i].rdy) begin
        push(exp_idx, tbl[i].d);
        exp_idx++;
      end
      @(negedge clk);
      check("tbl_in_ready", 64'(in_ready), 64'(tbl[i].rdy));
      check("tbl_w_en", 64'(w_en), 64'(tbl[i].wen));
      check("tbl_w_addr", 64'(w_addr), 64'(tbl[i].wa));
      check("tbl_w_data", 64'(w_data), 64'(tbl[i].wd));
      check("tbl_busy", 64'(busy), 64'(tbl[i].bsy));
      check("tbl_done", 64'(done), 64'(tbl[i].dn));
      tick();
    end

    // Reset after 5 accepted words, then a fresh burst from address 0.
    do_reset();
    dc0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 34'h100 + 34'(i);
      push(i, in_data);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_w_en", 64'(w_en), 0);
    check("midrst_w_addr", 64'(w_addr), 0);
    check("midrst_w_data", 64'(w_data), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_in_ready", 64'(in_ready), 0);
    check("midrst_done", 64'(done), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", 64'(done_cnt - dc0), 0);
    check("midrst_sb_empty", 64'(sb.size()), 0);
    run_burst(34'h200, last_acc);
    repeat (4) tick();
    check("midrst_new_done", 64'(done_cnt - dc0), 1);

    // start held high: bursts repeat with period 11 (IDLE, 8x LOAD, DRAIN, DONE).
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 33; k++) begin
      int ph;
      ph       = k % 11;
      start    = (k <= 22);
      in_data  = 34'h3_0000_0000 + 34'(k);
      if (ph >= 1 && ph <= 8) push(ph - 1, in_data);
      @(negedge clk);
      check("held_busy", 64'(busy), 64'(ph != 0));
      check("held_done", 64'(done), 64'(ph == 10));
      check("held_in_ready", 64'(in_ready), 64'(ph >= 1 && ph <= 8));
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();

    // NUM_WORDS=3 instance: three writes, in_ready low in DRAIN, then done.
    do_reset();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    in_valid3 = 1'b1;
    in_data3 = 34'h2AAAAAAAA;
    @(negedge clk);
    check("n3_c1_ready", 64'(in_ready3), 1);
    check("n3_c1_wen", 64'(w_en3), 0);
    tick();
    in_data3 = 34'h155555555;
    @(negedge clk);
    check("n3_c2_wen", 64'(w_en3), 1);
    check("n3_c2_addr", 64'(w_addr3), 0);
    check("n3_c2_data", 64'(w_data3), 64'h2AAAAAAAA);
    tick();
    in_data3 = 34'h3FFFFFFFF;
    @(negedge clk);
    check("n3_c3_addr", 64'(w_addr3), 1);
    check("n3_c3_data", 64'(w_data3), 64'h155555555);
    tick();
    in_data3 = 34'h0DEAD;  // still valid: must not be taken in DRAIN
    @(negedge clk);
    check("n3_drain_ready", 64'(in_ready3), 0);
    check("n3_drain_wen", 64'(w_en3), 1);
    check("n3_drain_addr", 64'(w_addr3), 2);
    check("n3_drain_data", 64'(w_data3), 64'h3FFFFFFFF);
    check("n3_drain_done", 64'(done3), 0);
    tick();
    in_valid3 = 1'b0;
    @(negedge clk);
    check("n3_done", 64'(done3), 1);
    check("n3_done_wen", 64'(w_en3), 0);
    check("n3_done_busy", 64'(busy3), 1);
    check("n3_error", 64'(error3), 0);
    tick();
    @(negedge clk);
    check("n3_idle_done", 64'(done3), 0);
    check("n3_idle_busy", 64'(busy3), 0);
    check("n3_idle_wen", 64'(w_en3), 0);
    check("n3_idle_data", 64'(w_data3), 64'h3FFFFFFFF);
    tick();

`ifdef VECTOR_A_LOADER_TIMEOUT_EN
    // Timeout: 2 words then silence; error one cycle after the 4th idle cycle.
    do_reset();
    dc0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 34'h40 + 34'(i);
      push(i, in_data);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_wait_error", 64'(error), 0);
      check("to_wait_busy", 64'(busy), 1);
      tick();
    end
    @(negedge clk);
    check("to_error", 64'(error), 1);
    check("to_busy", 64'(busy), 0);
    tick();
    @(negedge clk);
    check("to_error_pulse", 64'(error), 0);
    tick();
    check("to_no_done", 64'(done_cnt - dc0), 0);
    check("to_rf0", 64'(rf[0]), 64'h40);
    check("to_rf1", 64'(rf[1]), 64'h41);
`endif

    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
